// File: rtl/iter_mult_core.sv
// Iterative shift-add multiplier: one partial product per clock, 2*WIDTH-bit result.
// Define ITER_MULT_SIGNED_EN to add two's-complement support selected per operation by i_signed_op.
module iter_mult_core #(
    parameter int WIDTH = 32
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic               i_signed_op,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_ready,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_p
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_ra, r_mq, r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_done;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH:0]     w_sum;
    logic               w_accept, w_last;

    assign w_accept = (r_state == S_IDLE) && i_start;
    assign w_last   = (r_state == S_RUN) && (r_cnt == '0);

`ifdef ITER_MULT_SIGNED_EN
    logic r_sgn;

    // Signed mode sign-extends both terms; the last multiplier bit carries weight -2^(WIDTH-1).
    always_comb begin
        w_sum = r_sgn ? {r_acc[WIDTH-1], r_acc} : {1'b0, r_acc};
        if (r_mq[0]) begin
            if (r_sgn && w_last)
                w_sum = {r_acc[WIDTH-1], r_acc} - {r_ra[WIDTH-1], r_ra};
            else if (r_sgn)
                w_sum = {r_acc[WIDTH-1], r_acc} + {r_ra[WIDTH-1], r_ra};
            else
                w_sum = {1'b0, r_acc} + {1'b0, r_ra};
        end
    end
`else
    logic w_unused_signed_op;
    assign w_unused_signed_op = i_signed_op;

    always_comb begin
        w_sum = {1'b0, r_acc};
        if (r_mq[0])
            w_sum = {1'b0, r_acc} + {1'b0, r_ra};
    end
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == '0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bit WIDTH of the adder (carry or sign) shifts into the top of {ACC,MQ}.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ra   <= '0;
            r_mq   <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_p    <= '0;
`ifdef ITER_MULT_SIGNED_EN
            r_sgn  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_ra  <= i_a;
                r_mq  <= i_b;
                r_acc <= '0;
                r_cnt <= CW'(WIDTH - 1);
`ifdef ITER_MULT_SIGNED_EN
                r_sgn <= i_signed_op;
`endif
            end else if (r_state == S_RUN) begin
                r_acc <= w_sum[WIDTH:1];
                r_mq  <= {w_sum[0], r_mq[WIDTH-1:1]};
                r_cnt <= r_cnt - CW'(1);
                if (w_last) begin
                    r_p    <= {w_sum, r_mq[WIDTH-1:1]};
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_ready = (r_state == S_IDLE);
    assign o_done  = r_done;
    assign o_p     = r_p;

endmodule

// File: doc/iter_mult_core.md
# iter_mult_core

Parametrised iterative shift-add multiplier: the successor of the fixed 32-bit multiplication unit. Computes a full-width 2·WIDTH-bit product of two WIDTH-bit operands, one partial product per clock, behind a start/ready handshake with a one-cycle done strobe. It sits beside the datapath as a multi-cycle arithmetic resource; operands are captured at accept, so the datapath is free to change them while the unit is busy.

## Interface
- WIDTH, 32: operand width in bits; legal range 2..64.
- clock  in  1  master clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted on a rising edge where start=1 and ready=1
- signed_op  in  1  1 = operands are two's complement; sampled at accept (see Configuration)
- A  in  WIDTH  multiplicand, sampled at accept only
- B  in  WIDTH  multiplier, sampled at accept only
- ready  out  1  unit idle, able to accept
- done  out  1  one-cycle strobe, P valid and updated this cycle
- P  out  2*WIDTH  product of the last completed operation, held until the next completion

## Operation
- Reset (any time, including mid-operation): state=IDLE, ready=1, done=0, P=0, internal registers and counter cleared; the operation in flight is discarded with no done.
- States: IDLE, RUN. No other states.
- IDLE: ready=1. On an accept edge: RA<=A, MQ<=B, ACC<=0, SGN<=signed_op, CNT<=WIDTH-1, state<=RUN, ready<=0, done<=0.
- RUN, each edge: if MQ[0]=1, ACC gets ACC+RA (WIDTH+1-bit adder, carry kept), else unchanged; then {ACC,MQ} shifts right one bit, with the adder carry (unsigned) or sign-correct bit (signed) entering the MSB. CNT decrements.
- Final iteration (CNT=0): perform the step, P<={ACC,MQ} result, done<=1, ready<=1, state<=IDLE.
- Unsigned result: P = A·B exactly, modulo nothing (2·WIDTH bits hold every product).
- start while ready=0 is ignored; A, B and signed_op changes during RUN have no effect.
- done is high for exactly one cycle per accepted operation; P changes only on that cycle or at reset.

## Timing
- Accept edge E0; iteration edges E1..EWIDTH; done=1 and new P in the cycle following EWIDTH. Latency: WIDTH edges after accept, so P is valid WIDTH cycles after the accept edge.
- ready low for exactly WIDTH cycles per operation.
- Back-to-back: start held high is accepted again on the edge immediately after the done cycle begins (the done cycle is also an IDLE cycle), giving a throughput of one product per WIDTH+1 cycles.
- No combinational path from inputs to outputs; all outputs are registered.

## Configuration
- ITER_MULT_SIGNED_EN defined: when SGN=1, the partial product is sign-extended into ACC bit WIDTH, and the final iteration (multiplier sign bit) subtracts RA instead of adding; the result is the exact two's-complement product A·B. When SGN=0, the operation is unsigned, exactly as without the macro.
- Undefined: the signed_op port is present but ignored; every operation is unsigned; the sign-handling logic is not synthesised.

## Test plan
- WIDTH=32, A=3, B=5, start pulse -> ready low for 32 cycles, done one cycle, P=0x0000000F; P holds after done.
- WIDTH=32, A=B=0xFFFFFFFF unsigned -> P=0xFFFFFFFE00000001.
- ITER_MULT_SIGNED_EN, signed_op=1, A=B=0xFFFFFFFF -> P=1; A=0x80000000, B=2 -> P=0xFFFFFFFF00000000; same stimulus without macro -> unsigned products.
- Accept A=7,B=6, then change A to 9 and pulse start mid-RUN -> single done, P=42, second start ignored.
- Hold start high with A=2,B=3 for 3 operations -> done every 33 cycles, P=6 each time.
- Assert reset_n low at iteration 10 -> ready=1, done=0, P=0 immediately; no done follows; next operation with A=4,B=4 gives P=16.
